rc_pulse_shaper_ctrl: RTL and testbench
=======================================

Name: rc_pulse_shaper_ctrl

Overview:
- Sequencer that feeds the RaisedCosine pulse-shaping filter.
- Accepts int16 symbols on a valid/ready handshake and upsamples them by zero-stuffing (one symbol, then SPS-1 zeros).
- Drives the filter's clock-enable and input, then flushes the filter tail with zeros after the last symbol.
- Qualifies the filter output with a valid/last strobe so downstream DAC/channel logic sees exactly one framed burst per start.

Parameters:
- SPS, 8, samples per symbol (upsampling factor), ≥2.
- FLUSH_LEN, 48, zero samples pushed after the last symbol's slot (filter span × SPS).
- PIPE_LAT, 2, filter latency in enabled cycles from In1 to Out1, ≥1.
- DW, 16, sample/symbol width, signed.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- clk_enable  in  1  global enable; when low the whole block freezes.
- start  in  1  one-cycle pulse; begins a burst from IDLE.
- sym_valid  in  1  symbol available.
- sym_data  in  DW  signed symbol value.
- sym_last  in  1  marks the final symbol of the burst.
- sym_ready  out  1  symbol accepted this cycle when high with sym_valid.
- filt_ce  out  1  to the filter's clk_enable.
- filt_in  out  DW  to the filter's In1.
- filt_ce_out  in  1  filter's ce_out.
- filt_out  in  DW  filter's Out1.
- out_valid  out  1  filtered sample valid.
- out_data  out  DW  filtered sample (filt_out passed through).
- out_last  out  1  final filtered sample of the burst.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse at burst end.
- underrun  out  1  sticky; a symbol slot was starved during this burst.

Behaviour:
- Reset:
  - Asynchronous.
  - State goes to IDLE and all counters clear.
  - All outputs are 0, including filt_in = 0 and the underrun flag.
- Freeze: while clk_enable = 0, no state, counter or output register changes; sym_ready = 0 and filt_ce = 0.
- States:
  - IDLE → RUN on start (clears underrun, phase = 0). start while busy is ignored.
  - RUN: phase counter cycles 0..SPS-1 every enabled cycle.
    - sym_ready = (RUN & phase==0 & clk_enable), combinational.
    - Phase 0 with sym_valid: register filt_in = sym_data and latch sym_last.
    - Phase 0 without sym_valid: register filt_in = 0 and set underrun (zero symbol inserted, stream never stalls).
    - Phases 1..SPS-1: filt_in = 0.
    - After the phase SPS-1 of the slot whose symbol had sym_last: → FLUSH.
  - FLUSH: FLUSH_LEN cycles of filt_in = 0, then → DRAIN.
  - DRAIN: PIPE_LAT cycles with filt_ce = 0, then → IDLE with a done pulse.
- filt_ce / filt_in timing:
  - Both are registered.
  - A sample decided in cycle t is presented with filt_ce = 1 in cycle t+1.
  - filt_ce = 1 every enabled cycle of RUN and FLUSH, and for the first presented sample.
  - filt_ce = 0 in IDLE and DRAIN.
- Output qualification:
  - A PIPE_LAT-deep shift register carries the filt_ce strobe plus a last-tag bit; it advances only when clk_enable = 1.
  - out_valid = delayed strobe & filt_ce_out.
  - out_data = filt_out.
  - out_last = delayed last-tag; it is set on the final FLUSH sample.
- Counts: a burst of N symbols (including inserted zeros) yields exactly N·SPS + FLUSH_LEN filt_ce cycles and the same number of out_valid cycles.
- Burst-end timing:
  - Final flush sample presented in cycle T ⇒ out_valid & out_last in T+PIPE_LAT.
  - done = 1 in T+PIPE_LAT+1, with busy = 0 in that same cycle.
- Simultaneous events:
  - start in the same cycle as done is ignored.
  - sym_last on an inserted zero cannot occur (no symbol present).
- Reset mid-burst (any state): immediate return to IDLE; any in-flight out_valid is suppressed.
- Arithmetic: no scaling or saturation; values pass through unmodified at DW bits, two's complement.

Test Plan:
- Nominal burst:
  - Stimulus: SPS=8, FLUSH_LEN=48, PIPE_LAT=2; start, then 4 symbols +32767, -32768, +32767, -32768 (last on the 4th), always valid.
  - Expect: filt_in = 32767, 7×0, -32768, 7×0, …; 80 filt_ce cycles; 80 out_valid; out_last on the 80th; done 1 cycle later; underrun = 0.
- Handshake spacing: sym_valid held high → sym_ready high exactly one cycle in every 8; the second symbol is accepted 8 cycles after the first.
- Underrun:
  - Stimulus: sym_valid low during the 2nd symbol slot, then resume.
  - Expect: 0 inserted in that slot, underrun = 1 until the next start, N=5 slots → 88 filt_ce cycles.
- clk_enable freeze: drop clk_enable for 5 cycles mid-RUN at phase 3 → filt_ce = 0, phase stays 3, outputs hold, and the sequence resumes unchanged; total counts are unaffected.
- Reset mid-FLUSH: assert reset 20 cycles into FLUSH → all outputs 0 asynchronously; no done or out_last; a following start runs a clean burst.
- start while busy: pulse start during RUN → ignored; the burst length is unchanged.

Source files
------------

// File: rtl/rc_pulse_shaper_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rc_pulse_shaper_ctrl
// Brief    : Zero-stuffing sequencer, tail flush and output framing for a
//            raised-cosine pulse-shaping filter.
// Revision : 1.0
// ============================================================================
module rc_pulse_shaper_ctrl #(
    parameter int SPS       = 8,
    parameter int FLUSH_LEN = 48,
    parameter int PIPE_LAT  = 2,
    parameter int DW        = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clk_enable,
    input  logic                 start,
    input  logic                 sym_valid,
    input  logic signed [DW-1:0] sym_data,
    input  logic                 sym_last,
    output logic                 sym_ready,
    output logic                 filt_ce,
    output logic signed [DW-1:0] filt_in,
    input  logic                 filt_ce_out,
    input  logic signed [DW-1:0] filt_out,
    output logic                 out_valid,
    output logic signed [DW-1:0] out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done,
    output logic                 underrun
);

    localparam int c_PH_W    = $clog2(SPS);
    localparam int c_CNT_MAX = (FLUSH_LEN > PIPE_LAT) ? FLUSH_LEN : PIPE_LAT;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_PH_W-1:0]     r_phase;
    logic [c_PH_W-1:0]     w_phase_nxt;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_CNT_W-1:0]    w_cnt_nxt;
    logic                  r_ce;
    logic                  w_ce_nxt;
    logic signed [DW-1:0]  r_fin;
    logic signed [DW-1:0]  w_fin_nxt;
    logic                  r_tag;
    logic                  w_tag_nxt;
    logic                  r_last_sym;
    logic                  w_last_sym_nxt;
    logic                  r_underrun;
    logic                  w_underrun_nxt;
    logic                  r_done;
    logic                  w_done_nxt;
    logic [PIPE_LAT-1:0]   r_vpipe;
    logic [PIPE_LAT-1:0]   r_lpipe;
    logic                  w_phase_end;

    assign w_phase_end = (r_phase == c_PH_W'(SPS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else if (clk_enable) begin
            r_state <= w_state_nxt;
        end
    end

    // Each enabled cycle of RUN/FLUSH decides one sample; it is presented next cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_phase_nxt    = r_phase;
        w_cnt_nxt      = r_cnt;
        w_ce_nxt       = 1'b0;
        w_fin_nxt      = '0;
        w_tag_nxt      = 1'b0;
        w_last_sym_nxt = r_last_sym;
        w_underrun_nxt = r_underrun;
        w_done_nxt     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !r_done) begin
                    w_state_nxt    = S_RUN;
                    w_phase_nxt    = '0;
                    w_underrun_nxt = 1'b0;
                    w_last_sym_nxt = 1'b0;
                end
            end
            S_RUN: begin
                w_ce_nxt    = 1'b1;
                w_phase_nxt = w_phase_end ? '0 : r_phase + c_PH_W'(1);
                if (r_phase == '0) begin
                    w_last_sym_nxt = sym_valid & sym_last;
                    if (sym_valid) begin
                        w_fin_nxt = sym_data;
                    end else begin
                        w_underrun_nxt = 1'b1;
                    end
                end
                if (w_phase_end && r_last_sym) begin
                    w_state_nxt = S_FLUSH;
                    w_cnt_nxt   = '0;
                end
            end
            S_FLUSH: begin
                w_ce_nxt  = 1'b1;
                w_cnt_nxt = r_cnt + c_CNT_W'(1);
                if (r_cnt == c_CNT_W'(FLUSH_LEN - 1)) begin
                    w_tag_nxt   = 1'b1;
                    w_state_nxt = S_DRAIN;
                    w_cnt_nxt   = '0;
                end
            end
            S_DRAIN: begin
                // First DRAIN cycle still presents the final flush sample.
                w_cnt_nxt = r_cnt + c_CNT_W'(1);
                if (r_cnt == c_CNT_W'(PIPE_LAT)) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase    <= '0;
            r_cnt      <= '0;
            r_ce       <= 1'b0;
            r_fin      <= '0;
            r_tag      <= 1'b0;
            r_last_sym <= 1'b0;
            r_underrun <= 1'b0;
            r_done     <= 1'b0;
            r_vpipe    <= '0;
            r_lpipe    <= '0;
        end else if (clk_enable) begin
            r_phase    <= w_phase_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ce       <= w_ce_nxt;
            r_fin      <= w_fin_nxt;
            r_tag      <= w_tag_nxt;
            r_last_sym <= w_last_sym_nxt;
            r_underrun <= w_underrun_nxt;
            r_done     <= w_done_nxt;
            r_vpipe[0] <= r_ce;
            r_lpipe[0] <= r_tag;
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
                r_lpipe[i] <= r_lpipe[i-1];
            end
        end
    end

    assign sym_ready = (r_state == S_RUN) && (r_phase == '0) && clk_enable;
    assign filt_ce   = r_ce & clk_enable;
    assign filt_in   = r_fin;
    assign out_valid = r_vpipe[PIPE_LAT-1] & filt_ce_out;
    assign out_last  = r_lpipe[PIPE_LAT-1];
    assign out_data  = reset ? '0 : filt_out;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign underrun  = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_rc_pulse_shaper_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rc_pulse_shaper_ctrl
// Brief    : Self-checking bench; expected sample streams come from a slot list.
// Revision : 1.0
// ============================================================================
module tb_rc_pulse_shaper_ctrl;

    localparam int SPS = 8;
    localparam int FL  = 48;
    localparam int PL  = 2;
    localparam int DW  = 16;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 clk_enable = 1'b1;
    logic                 start = 1'b0;
    logic                 sym_valid = 1'b0;
    logic signed [DW-1:0] sym_data = '0;
    logic                 sym_last = 1'b0;
    logic                 sym_ready, filt_ce, out_valid, out_last, busy, done, underrun;
    logic signed [DW-1:0] filt_in, out_data;
    logic signed [DW-1:0] filt_out = '0;
    logic                 filt_ce_out;

    int checks = 0;
    int errors = 0;

    rc_pulse_shaper_ctrl #(.SPS(SPS), .FLUSH_LEN(FL), .PIPE_LAT(PL), .DW(DW)) dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start),
        .sym_valid(sym_valid), .sym_data(sym_data), .sym_last(sym_last),
        .sym_ready(sym_ready), .filt_ce(filt_ce), .filt_in(filt_in),
        .filt_ce_out(filt_ce_out), .filt_out(filt_out), .out_valid(out_valid),
        .out_data(out_data), .out_last(out_last), .busy(busy), .done(done),
        .underrun(underrun)
    );

    always #5 clk = ~clk;
    assign filt_ce_out = clk_enable;
    always @(posedge clk) filt_out <= DW'($urandom);

    // Slot list describing one burst, and the stream it should produce
    int                   n_slots;
    bit                   slot_v [16];
    logic signed [DW-1:0] slot_d [16];
    logic signed [DW-1:0] exp_q [$];
    bit                   exp_ur;

    // Passive monitor
    bit                   mon_clr = 1'b0;
    int                   cyc = 0;
    logic signed [DW-1:0] cap [$];
    int                   rdy_q [$];
    int n_ov, n_last, last_at, last_ce_cyc, last_ov_cyc, n_done, done_cyc, data_err;
    logic done_busy;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (mon_clr) begin
            cap.delete(); rdy_q.delete();
            n_ov = 0; n_last = 0; last_at = 0; last_ce_cyc = 0; last_ov_cyc = 0;
            n_done = 0; done_cyc = 0; data_err = 0; done_busy = 1'b0;
        end else begin
            if (filt_ce === 1'b1) begin cap.push_back(filt_in); last_ce_cyc = cyc; end
            if (sym_ready === 1'b1) rdy_q.push_back(cyc);
            if (out_valid === 1'b1) begin
                n_ov = n_ov + 1;
                if (out_data !== filt_out) data_err = data_err + 1;
                if (out_last === 1'b1) begin n_last = n_last + 1; last_at = n_ov; last_ov_cyc = cyc; end
            end
            if (done === 1'b1) begin n_done = n_done + 1; done_cyc = cyc; done_busy = busy; end
        end
    end

    task automatic gen_random(input int n);
        n_slots = n;
        for (int k = 0; k < n; k++) begin
            slot_d[k] = DW'($urandom);
            slot_v[k] = (k == n - 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic begin_burst();
        exp_q.delete();
        exp_ur = 1'b0;
        for (int k = 0; k < n_slots; k++) begin
            exp_q.push_back(slot_v[k] ? slot_d[k] : DW'(0));
            if (!slot_v[k]) exp_ur = 1'b1;
            repeat (SPS - 1) exp_q.push_back('0);
        end
        repeat (FL) exp_q.push_back('0);
        @(posedge clk); #1 mon_clr = 1'b1;
        @(negedge clk); #1 mon_clr = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic drive_slots();
        int  k = 0;
        int  guard = 0;
        bit  r;
        sym_valid = slot_v[0]; sym_data = slot_d[0]; sym_last = slot_v[0] && (n_slots == 1);
        while (k < n_slots && guard < 2000) begin
            @(negedge clk); r = sym_ready;
            @(posedge clk); #1;
            guard++;
            if (r) begin
                k++;
                if (k < n_slots) begin
                    sym_valid = slot_v[k]; sym_data = slot_d[k]; sym_last = slot_v[k] && (k == n_slots - 1);
                end else begin
                    sym_valid = 1'b0; sym_data = '0; sym_last = 1'b0;
                end
            end
        end
        checks++;
        if (k != n_slots) begin errors++; $display("FAIL drive_timeout: slots taken %0d, expected %0d", k, n_slots); end
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL done_timeout: done seen %0d, expected 1", seen); end
    endtask

    task automatic check_burst(input string name);
        int bad = -1;
        #1;
        for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
            if (bad < 0 && cap[i] !== exp_q[i]) bad = i;
        checks++;
        if (cap.size() != exp_q.size()) begin errors++; $display("FAIL %s ce_count: got %0d, expected %0d", name, cap.size(), exp_q.size()); end
        checks++;
        if (bad >= 0) begin errors++; $display("FAIL %s filt_in[%0d]: got %0d, expected %0d", name, bad, cap[bad], exp_q[bad]); end
        checks++;
        if (n_ov != exp_q.size()) begin errors++; $display("FAIL %s out_valid_count: got %0d, expected %0d", name, n_ov, exp_q.size()); end
        checks++;
        if (n_last != 1 || last_at != exp_q.size()) begin errors++; $display("FAIL %s out_last: count %0d at %0d, expected 1 at %0d", name, n_last, last_at, exp_q.size()); end
        checks++;
        if (last_ov_cyc != last_ce_cyc + PL) begin errors++; $display("FAIL %s last_latency: got %0d, expected %0d", name, last_ov_cyc - last_ce_cyc, PL); end
        checks++;
        if (n_done != 1 || done_cyc != last_ce_cyc + PL + 1 || done_busy !== 1'b0) begin
            errors++; $display("FAIL %s done: count %0d offset %0d busy %b, expected 1 offset %0d busy 0", name, n_done, done_cyc - last_ce_cyc, done_busy, PL + 1);
        end
        checks++;
        if (data_err != 0) begin errors++; $display("FAIL %s out_data_passthrough: got %0d mismatches, expected 0", name, data_err); end
        checks++;
        if (underrun !== exp_ur) begin errors++; $display("FAIL %s underrun: got %b, expected %b", name, underrun, exp_ur); end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({sym_ready, filt_ce, out_valid, out_last, busy, done, underrun, filt_in, out_data} !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h, expected 0", {sym_ready, filt_ce, out_valid, out_last, busy, done, underrun, filt_in, out_data});
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({sym_ready, filt_ce, out_valid, out_last, busy, done, underrun, filt_in} !== '0) begin
            errors++; $display("FAIL idle_outputs: got %h, expected 0", {sym_ready, filt_ce, out_valid, out_last, busy, done, underrun, filt_in});
        end
        checks++;
        if (out_data !== filt_out) begin errors++; $display("FAIL idle_passthrough: got %0d, expected %0d", out_data, filt_out); end
    endtask

    task automatic test_nominal();
        int gap_err = 0;
        n_slots = 4;
        for (int k = 0; k < 4; k++) begin slot_v[k] = 1'b1; slot_d[k] = (k % 2 == 0) ? 16'sd32767 : -16'sd32768; end
        begin_burst();
        drive_slots();
        wait_done();
        check_burst("nominal");
        for (int i = 1; i < rdy_q.size(); i++) if (rdy_q[i] - rdy_q[i-1] != SPS) gap_err++;
        checks++;
        if (rdy_q.size() != 4 || gap_err != 0) begin errors++; $display("FAIL ready_spacing: %0d pulses %0d bad gaps, expected 4 pulses 0 bad gaps", rdy_q.size(), gap_err); end
        checks++;
        if (exp_q.size() != 80) begin errors++; $display("FAIL nominal_len: got %0d, expected 80", exp_q.size()); end
    endtask

    task automatic test_underrun();
        gen_random(5);
        slot_v[1] = 1'b0;
        begin_burst();
        drive_slots();
        wait_done();
        check_burst("underrun");
        checks++;
        if (cap.size() != 88) begin errors++; $display("FAIL underrun_len: got %0d, expected 88", cap.size()); end
        begin_burst();
        #1;
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_clear: got %b, expected 0", underrun); end
        gen_random(1);
        drive_slots();
        wait_done();
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            gen_random($urandom_range(1, 6));
            begin_burst();
            drive_slots();
            wait_done();
            check_burst("random");
        end
    endtask

    task automatic test_freeze();
        logic signed [DW-1:0] held;
        int bad = 0;
        n_slots = 4;
        for (int k = 0; k < 4; k++) begin slot_v[k] = 1'b1; slot_d[k] = DW'($urandom) | 16'sd1; end
        begin_burst();
        fork
            drive_slots();
            begin
                for (int i = 0; i < 100 && rdy_q.size() < 2; i++) @(posedge clk);
                repeat (2) @(posedge clk);
                #1 clk_enable = 1'b0;
                held = filt_in;
                repeat (5) begin
                    @(negedge clk);
                    if (filt_ce !== 1'b0 || sym_ready !== 1'b0 || filt_in !== held || busy !== 1'b1) bad++;
                end
                @(posedge clk); #1 clk_enable = 1'b1;
            end
        join
        wait_done();
        check_burst("freeze");
        checks++;
        if (bad != 0) begin errors++; $display("FAIL freeze_hold: got %0d bad cycles, expected 0", bad); end
        checks++;
        if (rdy_q.size() != 4 || rdy_q[2] - rdy_q[1] != SPS + 5 || rdy_q[3] - rdy_q[2] != SPS) begin
            errors++; $display("FAIL freeze_phase: got %0d pulses, expected gap %0d after freeze", rdy_q.size(), SPS + 5);
        end
    endtask

    task automatic test_reset_flush();
        gen_random(3);
        slot_v[1] = 1'b0;
        begin_burst();
        drive_slots();
        repeat (27) @(posedge clk);
        #3;
        checks++;
        if (busy !== 1'b1 || filt_ce !== 1'b1 || filt_in !== '0 || underrun !== 1'b1) begin
            errors++; $display("FAIL pre_reset_flush: busy %b ce %b in %0d ur %b, expected 1 1 0 1", busy, filt_ce, filt_in, underrun);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({sym_ready, filt_ce, out_valid, out_last, busy, done, underrun, filt_in, out_data} !== '0) begin
            errors++; $display("FAIL async_reset: got %h, expected 0", {sym_ready, filt_ce, out_valid, out_last, busy, done, underrun, filt_in, out_data});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (70) @(posedge clk);
        #1;
        checks++;
        if (n_done != 0 || n_last != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_abort: done %0d last %0d busy %b, expected 0 0 0", n_done, n_last, busy);
        end
        gen_random(3);
        for (int k = 0; k < 3; k++) slot_v[k] = 1'b1;
        begin_burst();
        drive_slots();
        wait_done();
        check_burst("post_reset");
    endtask

    task automatic test_start_busy();
        gen_random(3);
        begin_burst();
        fork
            drive_slots();
            begin
                repeat (5) @(posedge clk);
                #1 start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
            end
        join
        wait_done();
        check_burst("start_busy");
    endtask

    task automatic test_back_to_back();
        gen_random(2);
        begin_burst();
        drive_slots();
        wait_done();
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL start_on_done: busy %b, expected 0", busy); end
        check_burst("b2b_a");
        gen_random($urandom_range(2, 5));
        begin_burst();
        drive_slots();
        wait_done();
        check_burst("b2b_b");
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_underrun();
        test_random();
        test_freeze();
        test_reset_flush();
        test_start_busy();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
